// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage MIPS pipeline. It produces the forwarding selects,
// the stall and flush controls, mult/div busy sequencing and a stall-cycle statistic.
module hazard_unit #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       rsE,
    input  logic [4:0]       rtE,
    input  logic [4:0]       writeRegE,
    input  logic [4:0]       writeRegM,
    input  logic [4:0]       writeRegW,
    input  logic             regWriteE,
    input  logic             regWriteM,
    input  logic             regWriteW,
    input  logic             memToRegE,
    input  logic             memToRegM,
    input  logic             branchD,
    input  logic             jumpD,
    input  logic             pcSrcD,
    input  logic             mdStartD,
    input  logic             mdUseD,
    output logic             stallF,
    output logic             stallD,
    output logic             flushD,
    output logic             flushE,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             mdBusy,
    output logic [CNT_W-1:0] stallCount
);

    logic [3:0]       r_mdCnt;
    logic [CNT_W-1:0] r_stallCnt;

    logic w_wrE, w_wrM, w_wrW;
    logic w_lwStall, w_brStall, w_mdStall, w_stall;

    // Register 0 is hard-wired zero, so a write to it never creates a dependency.
    assign w_wrE = regWriteE && (writeRegE != 5'd0);
    assign w_wrM = regWriteM && (writeRegM != 5'd0);
    assign w_wrW = regWriteW && (writeRegW != 5'd0);

    always_comb begin
        forwardAE = 2'b00;
        if (w_wrM && writeRegM == rsE)      forwardAE = 2'b10;
        else if (w_wrW && writeRegW == rsE) forwardAE = 2'b01;
        forwardBE = 2'b00;
        if (w_wrM && writeRegM == rtE)      forwardBE = 2'b10;
        else if (w_wrW && writeRegW == rtE) forwardBE = 2'b01;
    end

    assign forwardAD = w_wrM && (writeRegM == rsD);
    assign forwardBD = w_wrM && (writeRegM == rtD);

    assign w_lwStall = memToRegE && (writeRegE != 5'd0) &&
                       (writeRegE == rsD || writeRegE == rtD);
    // The branch compares in decode, so an ALU result still in E or a load in M is too late.
    assign w_brStall = branchD &&
                       ((w_wrE && (writeRegE == rsD || writeRegE == rtD)) ||
                        (memToRegM && (writeRegM != 5'd0) &&
                         (writeRegM == rsD || writeRegM == rtD)));
    assign w_mdStall = mdBusy && (mdUseD || mdStartD);
    assign w_stall   = w_lwStall || w_brStall || w_mdStall;

    assign stallF = w_stall;
    assign stallD = w_stall;
    assign flushE = w_stall;
    assign flushD = (pcSrcD || jumpD) && !w_stall;

    always_ff @(posedge clk) begin
        if (rst)
            r_mdCnt <= 4'd0;
        else if (mdStartD && !w_stall)
            r_mdCnt <= 4'(MD_LATENCY);
        else if (r_mdCnt != 4'd0)
            r_mdCnt <= r_mdCnt - 4'd1;
    end

    assign mdBusy = (r_mdCnt != 4'd0);

    always_ff @(posedge clk) begin
        if (rst)
            r_stallCnt <= '0;
        else if (w_stall && r_stallCnt != {CNT_W{1'b1}})
            r_stallCnt <= r_stallCnt + 1'b1;
    end

    assign stallCount = r_stallCnt;

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Pipeline hazard controller for the 5-stage MIPS core. It generates the decode-stage branch-compare forwarding selects (forwardAD/forwardBD) and the execute-stage ALU operand forwarding selects. It also produces the stall and flush controls for the fetch, decode and execute stages. It sequences the multi-cycle multiply/divide unit with a busy counter and keeps a saturating stall-cycle statistic.

Parameters:
MD_LATENCY, 4, cycles the mult/div unit is busy after a mult/div leaves decode (1..15)
CNT_W, 16, width of the stall-cycle statistic counter

Ports:
clk  input  1  core clock, rising edge
rst  input  1  synchronous active-high reset
rsD  input  5  source register rs of the instruction in decode
rtD  input  5  source register rt of the instruction in decode
rsE  input  5  rs of the instruction in execute
rtE  input  5  rt of the instruction in execute
writeRegE  input  5  destination register in execute
writeRegM  input  5  destination register in memory
writeRegW  input  5  destination register in writeback
regWriteE  input  1  execute-stage instruction writes the register file
regWriteM  input  1  memory-stage instruction writes the register file
regWriteW  input  1  writeback-stage instruction writes the register file
memToRegE  input  1  execute-stage instruction is a load
memToRegM  input  1  memory-stage instruction is a load
branchD  input  1  decode holds beq/bne
jumpD  input  1  decode holds j
pcSrcD  input  1  decode branch resolved taken
mdStartD  input  1  decode holds mult/div
mdUseD  input  1  decode holds mfhi/mflo
stallF  output  1  hold PC
stallD  output  1  hold IF/ID register
flushD  output  1  clear IF/ID register
flushE  output  1  clear ID/EX register (inject bubble)
forwardAD  output  1  1 selects aluOutM for the branch comparand rs
forwardBD  output  1  1 selects aluOutM for the branch comparand rt
forwardAE  output  2  00 regfile, 01 resultW, 10 aluOutM for ALU operand A
forwardBE  output  2  same encoding for ALU operand B
mdBusy  output  1  mult/div unit busy
stallCount  output  CNT_W  saturating count of cycles with stallD=1

Behaviour:
- Register 0 never matches. Every comparison below also requires the compared writeReg to be nonzero.
- forwardAE/forwardBE are combinational.
  - 10 when regWriteM and writeRegM equals rsE (rtE for B).
  - Otherwise 01 when regWriteW and writeRegW matches.
  - Otherwise 00.
  - When both M and W match, M wins.
- forwardAD is combinational: regWriteM and writeRegM==rsD. forwardBD is the same with rtD.
- lwStall = memToRegE and writeRegE nonzero and (writeRegE==rsD or writeRegE==rtD).
- branchStall = branchD and either:
  - regWriteE and writeRegE in {rsD, rtD}, or
  - memToRegM and writeRegM in {rsD, rtD}.
- mdStall = mdBusy and (mdUseD or mdStartD). This covers both result-use and structural hazards.
- stall = lwStall or branchStall or mdStall. stallF = stallD = flushE = stall. All are combinational.
- flushD = (pcSrcD or jumpD) and not stall.
- Mult/div counter (4 bits, registered):
  - Reset to 0.
  - Loads MD_LATENCY on a clock edge where mdStartD=1 and stall=0.
  - Otherwise decrements while nonzero.
  - mdBusy = (counter != 0), registered-derived.
  - Example, MD_LATENCY=4: mult in decode at cycle t with no stall gives mdBusy=1 during cycles t+1..t+4 and 0 at t+5.
- stallCount (registered):
  - Reset to 0.
  - Increments on each edge where stallD=1.
  - Saturates at all-ones and never wraps.
- Reset:
  - On an rst edge, the counter and stallCount clear regardless of other inputs, including mid mult/div.
  - Combinational outputs follow their inputs. With all inputs 0, every output is 0.
- Simultaneous events:
  - If a load-use hazard and a taken branch occur together, stall wins: flushD=0 and flushE=1.
  - mdStartD during a stall does not load the counter.

Test Plan:
- Forward priority: rsE=5, regWriteM=1/writeRegM=5, regWriteW=1/writeRegW=5 -> forwardAE=10. Drop regWriteM -> 01. Set writeRegM=writeRegW=0 -> 00.
- Load-use: memToRegE=1, writeRegE=8, rtD=8 -> stallF=stallD=flushE=1 for exactly that cycle. Next cycle memToRegE=0 -> all 0. stallCount increments by 1.
- Branch: branchD=1, rsD=3, regWriteE=1/writeRegE=3 -> stall. Next cycle regWriteM=1/writeRegM=3 (not a load) -> no stall, forwardAD=1. Then pcSrcD=1 -> flushD=1.
- Mult/div, MD_LATENCY=4: mdStartD at cycle 0 -> mdBusy=1 cycles 1-4. mfhi (mdUseD) at cycle 2 -> stall cycles 2-4, released at cycle 5.
- Reset mid-op: assert rst at cycle 2 of a mult/div -> mdBusy=0 and stallCount=0 next cycle.
- Saturation: CNT_W=4, hold stall 20 cycles -> stallCount stops at 15.
- Register 0: writeRegE=0, memToRegE=1, rsD=0 -> no stall.
